// File: rtl/boreal_mailbox_mc.sv
// boreal_mailbox_mc: CH-window mailbox with per-window doorbell ownership FSM and write gating
module boreal_mailbox_mc #(
    parameter int DW    = 32,
    parameter int WORDS = 256,
    parameter int CH    = 4,
    localparam int AW   = $clog2(WORDS),
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [DW/8-1:0]   cpu_wstrb,
    output logic [DW-1:0]     cpu_rdata,
    input  logic [CH-1:0]     cpu_ring,
    input  logic [CH-1:0]     cpu_clear,
    input  logic [AW-1:0]     a_ridx,
    output logic [DW-1:0]     a_rdata,
    input  logic              b_we,
    input  logic [AW-1:0]     b_widx,
    input  logic [DW-1:0]     b_wdata,
    input  logic [CH-1:0]     b_accept,
    input  logic [CH-1:0]     b_done,
    output logic [2*CH-1:0]   ch_state,
    output logic [CH-1:0]     irq_int,
    output logic [CH-1:0]     irq_cpu,
    output logic [CH-1:0]     err
);
    localparam int LCH = $clog2(CH);
    localparam int NB  = DW / 8;
    localparam logic [1:0] EMPTY = 2'd0, FULL = 2'd1, BUSY = 2'd2, DONE = 2'd3;

    logic [DW-1:0]      mem [WORDS] = '{default: '0};
    logic [CH-1:0][1:0] st_q, st_d;
    logic [CH-1:0]      err_q, err_d, is_e, is_f, is_b, is_d;
    logic [CH-1:0]      l_ring, l_acc, l_clr, l_done, bad, werr;
    logic [CW-1:0]      cpu_ch, b_ch;
    logic               cpu_ok, b_ok;
    logic [DW-1:0]      cpu_rdata_q, a_rdata_q;

    function automatic logic [CW-1:0] ch_of(input logic [AW-1:0] idx);
        return CW'(idx >> (AW - LCH));
    endfunction

    assign cpu_ch = ch_of(cpu_addr);
    assign b_ch   = ch_of(b_widx);

    always_comb begin
        for (int n = 0; n < CH; n++) begin
            is_e[n] = st_q[n] == EMPTY;
            is_f[n] = st_q[n] == FULL;
            is_b[n] = st_q[n] == BUSY;
            is_d[n] = st_q[n] == DONE;
        end
    end

    // Write gating looks at the pre-edge state, so a write alongside ring still lands
    assign cpu_ok = cpu_we && (|cpu_wstrb) && is_e[cpu_ch];
    assign b_ok   = b_we && is_b[b_ch];

    always_comb begin
        l_ring = cpu_ring & is_e;
        l_acc  = b_accept & is_f;
        l_clr  = cpu_clear & (is_d | (is_f & ~b_accept));
        l_done = b_done & is_b;
        bad    = (cpu_ring & ~l_ring) | (b_accept & ~l_acc) | (cpu_clear & ~l_clr) | (b_done & ~l_done);
        werr   = ((cpu_we && (|cpu_wstrb) && !cpu_ok) ? (CH'(1) << cpu_ch) : '0)
               | ((b_we && !b_ok) ? (CH'(1) << b_ch) : '0);
        for (int n = 0; n < CH; n++)
            st_d[n] = l_ring[n] ? FULL : l_acc[n] ? BUSY : l_clr[n] ? EMPTY : l_done[n] ? DONE : st_q[n];
        err_d = (err_q & ~l_clr) | bad | werr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= '0;
            err_q       <= '0;
            cpu_rdata_q <= '0;
            a_rdata_q   <= '0;
        end else begin
            st_q        <= st_d;
            err_q       <= err_d;
            cpu_rdata_q <= mem[cpu_addr];
            a_rdata_q   <= mem[a_ridx];
        end
    end

    // B is written last so it owns the word on a same-index collision
    always_ff @(posedge clk) begin
        if (!rst && cpu_ok)
            for (int i = 0; i < NB; i++)
                if (cpu_wstrb[i]) mem[cpu_addr][8*i +: 8] <= cpu_wdata[8*i +: 8];
        if (!rst && b_ok) mem[b_widx] <= b_wdata;
    end

    always_comb begin
        ch_state  = st_q;
        irq_int   = is_f;
        irq_cpu   = is_d;
        err       = err_q;
        cpu_rdata = cpu_rdata_q;
        a_rdata   = a_rdata_q;
    end
endmodule
